alu_md_seq: RTL and testbench
=============================

Name: alu_md_seq

Overview:
- Iterative multiply/divide sequencer that time-shares the 32-bit ALU to execute unsigned multiply (multu) and unsigned divide (divu) over 32 cycles.
- Also handles single-cycle writes to HI/LO (mthi/mtlo).
- Sits beside the ALU in the execute stage: it drives the ALU operand and opcode inputs while busy, and presents HI/LO plus a Busy flag to the pipeline controller.

Parameters:
- WIDTH, 32, operand/result width; the only supported value is 32.
- ITER, 32, iterations per multiply/divide; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous active-high reset.
- Start  input  1  launch request; sampled only when Busy=0.
- MDOp  input  2  00 multu, 01 divu, 10 mthi, 11 mtlo.
- A  input  32  multiplicand / dividend / mthi-mtlo data.
- B  input  32  multiplier / divisor.
- alu_Result  input  32  ALU Result output.
- alu_A  output  32  ALU operand A.
- alu_B  output  32  ALU operand B.
- alu_ALUOp  output  3  ALU opcode: 010 add, 011 sub, 000 when idle.
- Busy  output  1  high while a multu/divu is in progress.
- HI  output  32  high word / remainder.
- LO  output  32  low word / quotient.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset.
- Reset values: state IDLE, Busy=0, HI=0, LO=0, cnt=0, all working registers 0.
- In IDLE the ALU inputs are forced to alu_A=0, alu_B=0, alu_ALUOp=000.
- States: IDLE, MUL, DIV.
- IDLE transitions, on a clk edge with Start=1:
  - MDOp=00: latch M=A, Q=B, P=0, cnt=0; go to MUL.
  - MDOp=01: latch D=B, Q=A, R=0, cnt=0; go to DIV.
  - MDOp=10: HI<=A at that edge; stay in IDLE; Busy stays 0.
  - MDOp=11: LO<=A at that edge; stay in IDLE; Busy stays 0.
- Start while Busy=1: ignored completely; operands are not latched and HI/LO are unaffected.
- Busy is combinational from state (Busy = state!=IDLE). It is 1 for exactly ITER cycles following the launch edge.
- MUL iteration (one per edge):
  - ALU drive: alu_A=P, alu_B=M, alu_ALUOp=010.
  - carry = (alu_Result < P), unsigned compare.
  - If Q[0]=1: {c,s} = {carry, alu_Result}. Otherwise {c,s} = {0, P}.
  - Update: P<={c, s[31:1]}; Q<={s[0], Q[31:1]}; cnt<=cnt+1.
- DIV iteration (restoring division, one per edge):
  - S = {R[30:0], Q[31]}; msb = R[31].
  - ALU drive: alu_A=S, alu_B=D, alu_ALUOp=011.
  - borrow = (S < D), unsigned compare.
  - If msb | ~borrow: R<=alu_Result; Q<={Q[30:0],1}. Otherwise: R<=S; Q<={Q[30:0],0}.
  - cnt<=cnt+1.
- Completion: the edge with cnt==ITER-1 performs the last iteration and returns to IDLE.
  - MUL writes HI<=final P, LO<=final Q.
  - DIV writes HI<=final R, LO<=final Q.
  - Both are visible the cycle after that edge, when Busy=0.
- HI/LO hold their previous values for the whole operation; partial results are never exposed.
- Divide by zero needs no special case. The algorithm yields LO=0xFFFFFFFF, HI=dividend.
- Arithmetic is modulo 2^32 in the ALU. The 33rd bit comes only from the carry/msb logic above.
- Reset during MUL/DIV: at that edge return to IDLE, HI=LO=0, and abort the operation. Start is ignored on that edge.
- Start asserted on the same edge as completion is not accepted: Busy=1 on that edge. A new launch is accepted from the next edge.
- Signed operations are out of scope for this block.

Test Plan:
All scenarios use the bench with the ALU instantiated and wired to the alu_* ports.
- multu A=0xFFFFFFFF B=0xFFFFFFFF -> Busy high exactly 32 cycles; afterwards HI=0xFFFFFFFE, LO=0x00000001.
- multu A=0x00012345 B=0x00010000 -> HI=0x00000001, LO=0x23450000. During the run HI/LO hold the prior values.
- divu A=100 B=7 -> LO=14, HI=2. Second case: divu A=0x80000000 B=3 -> LO=0x2AAAAAAA, HI=2.
- divu A=0x00001234 B=0 -> LO=0xFFFFFFFF, HI=0x00001234 after 32 cycles.
- mthi A=0xDEADBEEF then mtlo A=0x12345678 on consecutive edges -> HI=0xDEADBEEF, LO=0x12345678; Busy never rises. Then start multu and pulse Start with divu at cycle 10 -> the divu is ignored and the multu result is unaffected.
- Start multu, assert reset at cycle 15 -> next cycle Busy=0, HI=LO=0, alu_ALUOp=000. A fresh divu 100/7 then completes correctly.

Source files
------------

// File: rtl/alu_md_seq.sv
// Iterative unsigned multiply/divide sequencer that borrows the execute-stage ALU
// for one add or subtract per cycle, plus single-cycle HI/LO writes.
module alu_md_seq #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] alu_Result,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [2:0]       alu_ALUOp,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  p, q, m, d, r;
  logic [WIDTH-1:0]  p_nxt, q_nxt, r_nxt;
  logic [WIDTH-1:0]  s_div;
  logic [WIDTH:0]    sum;
  logic              carry, borrow;
  logic              last;

  assign last      = (cnt == CW'(ITER - 1));
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; Start is only looked at while idle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (Start && MDOp == 2'b00)      state_nxt = S_MUL;
        else if (Start && MDOp == 2'b01) state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: ALU drive and Busy
  always_comb begin
    alu_A     = '0;
    alu_B     = '0;
    alu_ALUOp = 3'b000;
    Busy      = 1'b0;
    case (state)
      S_MUL: begin
        alu_A     = p;
        alu_B     = m;
        alu_ALUOp = OP_ADD;
        Busy      = 1'b1;
      end
      S_DIV: begin
        alu_A     = s_div;
        alu_B     = d;
        alu_ALUOp = OP_SUB;
        Busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // One shift-add (multiply) or restoring-subtract (divide) step per cycle.
  // The ALU only returns 32 bits, so the 33rd bit is rebuilt from compares.
  always_comb begin
    s_div  = {r[WIDTH-2:0], q[WIDTH-1]};
    carry  = (alu_Result < p);
    borrow = (s_div < d);
    sum    = q[0] ? {carry, alu_Result} : {1'b0, p};
    p_nxt  = p;
    q_nxt  = q;
    r_nxt  = r;
    case (state)
      S_MUL: begin
        p_nxt = sum[WIDTH:1];
        q_nxt = {sum[0], q[WIDTH-1:1]};
      end
      S_DIV: begin
        if (r[WIDTH-1] | ~borrow) begin
          r_nxt = alu_Result;
          q_nxt = {q[WIDTH-2:0], 1'b1};
        end else begin
          r_nxt = s_div;
          q_nxt = {q[WIDTH-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // Working registers and HI/LO; HI/LO change only on mthi/mtlo or completion
  always_ff @(posedge clk) begin
    if (reset) begin
      p   <= '0;
      q   <= '0;
      m   <= '0;
      d   <= '0;
      r   <= '0;
      cnt <= '0;
      HI  <= '0;
      LO  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            case (MDOp)
              2'b00: begin
                m   <= A;
                q   <= B;
                p   <= '0;
                cnt <= '0;
              end
              2'b01: begin
                d   <= B;
                q   <= A;
                r   <= '0;
                cnt <= '0;
              end
              2'b10: HI <= A;
              default: LO <= A;
            endcase
          end
        end
        S_MUL: begin
          p   <= p_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            HI <= p_nxt;
            LO <= q_nxt;
          end
        end
        S_DIV: begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            HI <= r_nxt;
            LO <= q_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_seq.sv
// Bench for alu_md_seq: a simple add/sub ALU, a transaction-level HI/LO model
// compared every cycle, and directed vectors with hand-computed results.
module tb_alu_md_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  mdop;
  logic [31:0] a, b;
  logic [31:0] alu_result, alu_a, alu_b;
  logic [2:0]  alu_aluop;
  logic        busy;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  alu_md_seq #(.WIDTH(32), .ITER(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (start),
    .MDOp       (mdop),
    .A          (a),
    .B          (b),
    .alu_Result (alu_result),
    .alu_A      (alu_a),
    .alu_B      (alu_b),
    .alu_ALUOp  (alu_aluop),
    .Busy       (busy),
    .HI         (hi),
    .LO         (lo),
    .dbg_state  (dbg_state)
  );

  // Execute-stage ALU: only add and subtract are used by the sequencer
  assign alu_result = (alu_aluop == 3'b010) ? alu_a + alu_b :
                      (alu_aluop == 3'b011) ? alu_a - alu_b : 32'h0;

  // ---------------- clock/reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check helper ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Transaction level: a launched op resolves to its arithmetic result after 32 edges.
  int          m_left = 0;
  logic [2:0]  m_op   = 3'b000;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [31:0] pend_hi, pend_lo;
  logic [63:0] prod;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
      m_op   = 3'b000;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = pend_hi;
        m_lo = pend_lo;
        m_op = 3'b000;
      end
    end else if (start) begin
      case (mdop)
        2'b00: begin
          prod    = 64'(a) * 64'(b);
          pend_hi = prod[63:32];
          pend_lo = prod[31:0];
          m_left  = 32;
          m_op    = 3'b010;
        end
        2'b01: begin
          pend_hi = (b == 0) ? a : a % b;
          pend_lo = (b == 0) ? 32'hFFFF_FFFF : a / b;
          m_left  = 32;
          m_op    = 3'b011;
        end
        2'b10: m_hi = a;
        default: m_lo = a;
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check32("busy", {31'b0, busy}, {31'b0, m_left != 0});
    check32("state_active", {31'b0, dbg_state != 2'b00}, {31'b0, m_left != 0});
    check32("hi", hi, m_hi);
    check32("lo", lo, m_lo);
    check32("alu_op", {29'b0, alu_aluop}, {29'b0, m_op});
    if (m_left == 0) begin
      check32("idle_alu_a", alu_a, 32'h0);
      check32("idle_alu_b", alu_b, 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1;
    mdop  = op;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts observed busy cycles, bounded so a stuck DUT cannot hang the run
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check32("wait_idle_timeout", {31'b0, busy === 1'b1}, 32'h0);
  endtask

  int n;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mdop  = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check32("rst_hi", hi, 32'h0);
    check32("rst_lo", lo, 32'h0);
    check32("rst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;

    // multu max * max
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    check32("mul_max_cycles", n, 32);
    check32("mul_max_hi", hi, 32'hFFFF_FFFE);
    check32("mul_max_lo", lo, 32'h0000_0001);

    // multu with HI/LO holding prior values mid-run
    launch(2'b00, 32'h0001_2345, 32'h0001_0000);
    repeat (10) @(negedge clk);
    check32("mul_hold_hi", hi, 32'hFFFF_FFFE);
    check32("mul_hold_lo", lo, 32'h0000_0001);
    wait_idle(n);
    check32("mul2_hi", hi, 32'h0000_0001);
    check32("mul2_lo", lo, 32'h2345_0000);

    // divu
    launch(2'b01, 32'd100, 32'd7);
    wait_idle(n);
    check32("div_cycles", n, 32);
    check32("div1_lo", lo, 32'd14);
    check32("div1_hi", hi, 32'd2);
    launch(2'b01, 32'h8000_0000, 32'd3);
    wait_idle(n);
    check32("div2_lo", lo, 32'h2AAA_AAAA);
    check32("div2_hi", hi, 32'd2);

    // divide by zero
    launch(2'b01, 32'h0000_1234, 32'h0);
    wait_idle(n);
    check32("div0_cycles", n, 32);
    check32("div0_lo", lo, 32'hFFFF_FFFF);
    check32("div0_hi", hi, 32'h0000_1234);

    // mthi then mtlo on consecutive edges
    @(negedge clk);
    start = 1'b1; mdop = 2'b10; a = 32'hDEAD_BEEF;
    @(negedge clk);
    check32("mthi_busy", {31'b0, busy}, 32'h0);
    mdop = 2'b11; a = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    check32("mthi_hi", hi, 32'hDEAD_BEEF);
    check32("mtlo_lo", lo, 32'h1234_5678);
    check32("mt_busy", {31'b0, busy}, 32'h0);

    // Start during busy is ignored
    launch(2'b00, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    start = 1'b1; mdop = 2'b01; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_idle(n);
    check32("ign_cycles", n, 22);
    check32("ign_hi", hi, 32'h0);
    check32("ign_lo", lo, 32'd15);
    @(negedge clk);
    check32("ign_no_relaunch", {31'b0, busy}, 32'h0);

    // Start on the completion edge is not accepted
    launch(2'b00, 32'd6, 32'd7);
    repeat (31) @(negedge clk);
    start = 1'b1; mdop = 2'b10; a = 32'hAAAA_5555;
    @(negedge clk);
    start = 1'b0;
    check32("cmpl_busy", {31'b0, busy}, 32'h0);
    check32("cmpl_hi", hi, 32'h0);
    check32("cmpl_lo", lo, 32'd42);

    // Reset mid-operation, with Start asserted on the reset edge
    launch(2'b00, 32'h1111_1111, 32'h2222_2222);
    repeat (14) @(negedge clk);
    reset = 1'b1; start = 1'b1; mdop = 2'b10; a = 32'h5A5A_5A5A;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check32("rst_mid_busy", {31'b0, busy}, 32'h0);
    check32("rst_mid_hi", hi, 32'h0);
    check32("rst_mid_lo", lo, 32'h0);
    check32("rst_mid_aluop", {29'b0, alu_aluop}, 32'h0);
    launch(2'b01, 32'd100, 32'd7);
    wait_idle(n);
    check32("post_rst_cycles", n, 32);
    check32("post_rst_lo", lo, 32'd14);
    check32("post_rst_hi", hi, 32'd2);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
